// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and sizing helper for the serial arithmetic datapaths.
package arith_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: single-bit combinational x - y - bin with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - borrow_in, LSB first, one bit per clock.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);
  localparam int CW = cnt_width(WIDTH);
  sub_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, diff_sr_q, diff_q, diff_d;
  logic             borrow_q, a_msb_q, b_msb_q;
  logic             busy_q, done_q, borrow_out_q, overflow_q;
  logic             d_bit, bout_bit, last_bit;
  full_subtractor u_fs (
    .x   (a_sr_q[0]),
    .y   (b_sr_q[0]),
    .bin (borrow_q),
    .d   (d_bit),
    .bout(bout_bit)
  );
  assign diff_d   = {d_bit, diff_sr_q[WIDTH-1:1]};
  assign last_bit = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      diff_sr_q    <= '0;
      borrow_q     <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          a_sr_q    <= a_sr_q >> 1;
          b_sr_q    <= b_sr_q >> 1;
          diff_sr_q <= diff_d;
          borrow_q  <= bout_bit;
          cnt_q     <= cnt_q + CW'(1);
          if (last_bit) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            diff_q       <= diff_d;
            borrow_out_q <= bout_bit;
            overflow_q   <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= SHIFT;
            busy_q   <= 1'b1;
            a_sr_q   <= a;
            b_sr_q   <= b;
            borrow_q <= borrow_in;
            a_msb_q  <= a[WIDTH-1];
            b_msb_q  <= b[WIDTH-1];
            cnt_q    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, borrow_in = 1'b0;
  logic [7:0] a = '0, b = '0, diff;
  logic       busy, done, borrow_out, overflow;
  int         n_cmp = 0, n_err = 0;
  logic [7:0] e_diff = '0;
  logic       e_bo = 1'b0, e_ov = 1'b0;
  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_held(input string tag);
    chk({tag, "_diff"}, diff, e_diff);
    chk({tag, "_bo"}, borrow_out, e_bo);
    chk({tag, "_ov"}, overflow, e_ov);
  endtask
  // Caller is at a negedge; the start set here is taken at the next rising edge.
  task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic tbi, input bit inject);
    int sa, sb, r;
    logic [7:0] nd;
    a = ta; b = tb; borrow_in = tbi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
    chk("busy_rise", busy, 1); chk("done_low0", done, 0); chk_held("hold0");
    for (int i = 1; i <= 8; i++) begin
      start = (inject && i == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (i < 8) begin
        chk("busy_shift", busy, 1); chk("done_shift", done, 0); chk_held("hold_shift");
      end
    end
    start = 1'b0;
    r  = int'(ta) - int'(tb) - int'(tbi);
    nd = 8'(r);
    sa = int'(ta[7]); sb = int'(tb[7]);
    e_diff = nd; e_bo = r < 0; e_ov = (sa != sb) && (int'(nd[7]) != sa);
    chk("done_pulse", done, 1); chk("busy_fall", busy, 0); chk_held("result");
  endtask
  task automatic idle_after;
    @(negedge clk);
    chk("done_drop", done, 0); chk("busy_idle", busy, 0); chk_held("hold_idle");
  endtask
  initial begin
    #1; chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk_held("rst");
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    op(8'h50, 8'h20, 1'b0, 0); chk("basic", diff, 8'h30); idle_after;
    op(8'h20, 8'h50, 1'b0, 0); chk("under_diff", diff, 8'hD0); chk("under_bo", borrow_out, 1); idle_after;
    op(8'h00, 8'h00, 1'b1, 0); chk("bin_diff", diff, 8'hFF); chk("bin_bo", borrow_out, 1); idle_after;
    op(8'h80, 8'h01, 1'b0, 0); chk("ovf_diff", diff, 8'h7F); chk("ovf_ov", overflow, 1); idle_after;
    op(8'h33, 8'h11, 1'b0, 1); idle_after;
    op(8'h10, 8'h20, 1'b1, 0);
    op(8'h7F, 8'hFF, 1'b0, 0); idle_after;
    a = 8'h50; b = 8'h20; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; #1;
    e_diff = '0; e_bo = 1'b0; e_ov = 1'b0;
    chk("arst_busy", busy, 0); chk("arst_done", done, 0); chk_held("arst");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("arst_nodone", done, 0);
    end
    rst_n = 1'b1; @(negedge clk);
    op(8'h50, 8'h20, 1'b0, 0); chk("post_rst", diff, 8'h30); idle_after;
    for (int k = 0; k < 25; k++) begin
      op(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) idle_after;
    end
    idle_after;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
